// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Serial bit-sequence detector with a programmable pattern of
//               1..MAX_LEN bits, runtime overlap / non-overlap selection,
//               registered (Moore) match pulse and saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,          // asynchronous, active-low
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap_in,
  input  logic               clr_count,
  output logic               q,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cfg_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Active configuration
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;

  // Datapath and outputs
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Helper terms
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic               match_hit;
  logic [CNT_W-1:0]   cnt_base;

  // Match evaluation on the would-be updated history and fill count
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hist_next = {hist_q[MAX_LEN-2:0], din};
    fill_next = (fill_q < LEN_MAX) ? fill_q + LEN_W'(1) : fill_q;
    // A config load takes priority: the bit on that cycle is discarded
    match_hit = din_valid && !cfg_load && (len_q != '0) && (fill_next >= len_q)
                && (((hist_next ^ pattern_q) & len_mask) == '0);
  end

  // Next-state for config, history, fill, pulse and counter
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    q_d       = 1'b0;

    if (cfg_load) begin
      pattern_d = pattern_in;
      len_d     = (len_in > LEN_MAX) ? LEN_MAX : len_in;
      overlap_d = overlap_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      hist_d = hist_next;
      // Non-overlap mode consumes the matched bits so the next hit needs len fresh bits
      fill_d = (match_hit && !overlap_q) ? '0 : fill_next;
      q_d    = match_hit;
    end

    // Clear is applied first, so a coincident match leaves the count at one
    cnt_base = clr_count ? '0 : cnt_q;
    cnt_d    = (match_hit && (cnt_base != CNT_MAX)) ? cnt_base + CNT_W'(1) : cnt_base;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      q_q       <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q           = q_q;
  assign match_count = cnt_q;
  assign cfg_len     = len_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Scoreboard bench for seq_detector_param; a queue-based
//               reference model predicts q / match_count / cfg_len per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_SAT = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pattern_in = '0;
  logic [LEN_W-1:0]   len_in = '0;
  logic               overlap_in = 1'b0;
  logic               clr_count = 1'b0;
  logic               q;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   cfg_len;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pattern_in(pattern_in), .len_in(len_in), .overlap_in(overlap_in),
    .clr_count(clr_count), .q(q), .match_count(match_count), .cfg_len(cfg_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             q;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   matches_seen = 0;

  // Reference model: the bits received since the last clear, newest last
  bit       m_bits[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_cnt;
  bit       m_q;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat = '0; m_len = 0; m_ovl = 1'b0; m_cnt = 0; m_q = 1'b0;
  endtask

  task automatic model_step(input bit cl, input bit dv, input bit d, input bit clr,
                            input bit [7:0] pat, input int ln, input bit ov);
    bit hit = 1'b0;
    if (cl) begin
      m_pat = pat;
      m_len = (ln > MAX_LEN) ? MAX_LEN : ln;
      m_ovl = ov;
      m_bits.delete();
    end else if (dv) begin
      m_bits.push_back(d);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      if (m_len != 0 && m_bits.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_bits.delete();
    end
    if (clr) m_cnt = 0;
    if (hit) begin
      m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
      matches_seen++;
    end
    m_q = hit;
  endtask

  task automatic push_exp();
    exp_t e;
    e.q = m_q; e.cnt = CNT_W'(m_cnt); e.len = LEN_W'(m_len);
    sb.push_back(e);
  endtask

  // One clock cycle of stimulus; the prediction is queued for the monitor
  task automatic step(input bit cl, input bit dv, input bit d, input bit clr,
                      input bit [7:0] pat, input int ln, input bit ov);
    @(negedge clk);
    cfg_load = cl; din_valid = dv; din = d; clr_count = clr;
    pattern_in = pat; len_in = LEN_W'(ln); overlap_in = ov;
    model_step(cl, dv, d, clr, pat, ln, ov);
    push_exp();
  endtask

  task automatic send(input bit b);
    step(1'b0, 1'b1, b, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic load(input bit [7:0] pat, input int ln, input bit ov);
    step(1'b1, 1'b0, 1'b0, 1'b0, pat, ln, ov);
  endtask

  // Asynchronous reset in the low clock phase, checked before any clock edge
  task automatic do_reset();
    @(negedge clk);
    cfg_load = 1'b0; din_valid = 1'b0; clr_count = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_cnt", int'(match_count), 0);
    chk("async_rst_len", int'(cfg_len), 0);
    model_reset();
    push_exp();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Monitor: the DUT presents a result every cycle just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("q", int'(q), int'(e.q));
        chk("match_count", int'(match_count), int'(e.cnt));
        chk("cfg_len", int'(cfg_len), int'(e.len));
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();

    // Non-overlap 1010 on 101010: one match
    load(8'b0000_1010, 4, 1'b0);
    send(1); send(0); send(1); send(0); send(1); send(0);
    idle();
    // Overlap on the same stream: two matches
    load(8'b0000_1010, 4, 1'b1);
    send(1); send(0); send(1); send(0); send(1); send(0);
    idle();
    // Gaps in din_valid keep partial progress
    load(8'b0000_1010, 4, 1'b1);
    send(1); send(0); send(1); idle(); idle(); idle(); send(0);
    idle();
    // Length clamp, then disabled detector
    load(8'hA5, 12, 1'b1);
    idle();
    do_reset();
    load(8'h00, 0, 1'b1);
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)));
    // len=1 back-to-back matches, saturation, clear coincident with a match
    load(8'h01, 1, 1'b1);
    for (int i = 0; i < 5; i++) send(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 0, 1'b0);
    idle();
    // Async reset mid-sequence discards progress
    load(8'b0000_1010, 4, 1'b0);
    send(1); send(0); send(1);
    do_reset();
    send(0);
    // Reload mid-sequence discards progress
    load(8'b0000_1010, 4, 1'b0);
    send(1); send(0); send(1);
    load(8'b0000_1010, 4, 1'b0);
    send(0);
    idle();

    // Randomized traffic, biased toward short patterns so matches occur
    for (int i = 0; i < 3000; i++) begin
      bit cl  = ($urandom_range(0, 39) == 0);
      bit dv  = ($urandom_range(0, 3) != 0);
      bit clr = ($urandom_range(0, 29) == 0);
      int ln  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4))
                                           : int'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(cl, dv, 1'($urandom_range(0, 1)), clr, 8'($urandom), ln,
                1'($urandom_range(0, 1)));
    end

    idle(); idle();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    if (matches_seen < 10) chk("match_activity", matches_seen, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
